// File: rtl/mac_sink_pkg.sv
// Shared defaults, pointer sizing and entry layout for the MAC result sink.
package mac_sink_pkg;

    localparam int DEF_ACC_WIDTH = 16;
    localparam int DEF_ID_WIDTH  = 1;
    localparam int DEF_DEPTH     = 4;

    // Index width for a FIFO of the given depth; never zero so a 1-bit slice always exists.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Canonical entry layout at default widths; modules mirror it with their own widths.
    typedef struct packed {
        logic [DEF_ACC_WIDTH-1:0] acc;
        logic [DEF_ID_WIDTH-1:0]  id;
    } mac_entry_t;

endpackage

// File: rtl/mac_sink_fifo.sv
// Result FIFO: storage, wrapping pointers and occupancy. Writes/reads arrive pre-qualified.
module mac_sink_fifo
    import mac_sink_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int W     = DEF_ACC_WIDTH + DEF_ID_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_clr,
    input  logic                    i_wr,
    input  logic                    i_rd,
    input  logic [W-1:0]            i_data,
    output logic [W-1:0]            o_head,
    output logic [ptr_w(DEPTH):0]   o_count,
    output logic [ptr_w(DEPTH):0]   o_count_next,
    output logic                    o_full,
    output logic                    o_empty
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_next;

    always_comb begin
        w_count_next = r_count;
        case ({i_wr, i_rd})
            2'b10:   w_count_next = r_count + CW'(1);
            2'b01:   w_count_next = r_count - CW'(1);
            default: w_count_next = r_count;
        endcase
    end

    // Storage is deliberately left out of reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (i_wr) r_mem[r_wr_ptr] <= i_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_wr) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (i_rd) r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count <= w_count_next;
        end
    end

    assign o_head       = r_mem[r_rd_ptr];
    assign o_count      = r_count;
    assign o_count_next = w_count_next;
    assign o_full       = (r_count == CW'(DEPTH));
    assign o_empty      = (r_count == '0);

endmodule

// File: rtl/mac_result_sink.sv
// Collects MAC pipeline results into a FIFO with registered backpressure and
// sticky overflow / out-of-order tag flags.
module mac_result_sink
    import mac_sink_pkg::*;
#(
    parameter int ACC_WIDTH = DEF_ACC_WIDTH,
    parameter int ID_WIDTH  = DEF_ID_WIDTH,
    parameter int DEPTH     = DEF_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   init_n,
    input  logic                   arrive,
    input  logic                   push_out_n,
    input  logic [ACC_WIDTH-1:0]   acc,
    input  logic [ID_WIDTH-1:0]    arrive_id,
    output logic                   accept_n,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ACC_WIDTH-1:0]   out_acc,
    output logic [ID_WIDTH-1:0]    out_id,
    output logic [ptr_w(DEPTH):0]  count,
    output logic                   ovf,
    output logic                   id_err
);

    localparam int CW = ptr_w(DEPTH) + 1;
    localparam logic [CW-1:0] ALMOST_FULL = CW'(DEPTH - 1);

    typedef struct packed {
        logic [ACC_WIDTH-1:0] acc;
        logic [ID_WIDTH-1:0]  id;
    } entry_t;

    entry_t        w_wdata;
    entry_t        w_head;
    logic [CW-1:0] w_count;
    logic [CW-1:0] w_count_next;
    logic          w_full;
    logic          w_empty;
    logic          w_capture;
    logic          w_pop;
    logic          w_wr;
    logic          w_rd;
    logic          w_drop;
    logic          w_tag_bad;

    logic                r_accept_n;
    logic [ID_WIDTH-1:0] r_exp_id;
    logic                r_ovf;
    logic                r_id_err;

    assign w_capture = arrive & ~push_out_n;
    assign w_pop     = ~w_empty & out_ready;
    // When full, a simultaneous pop frees the slot first, so the capture still lands.
    assign w_wr      = init_n & w_capture & (~w_full | w_pop);
    assign w_rd      = init_n & w_pop;
    assign w_drop    = w_capture & w_full & ~w_pop;
    assign w_tag_bad = w_capture & (arrive_id != r_exp_id);
    assign w_wdata   = '{acc: acc, id: arrive_id};

    mac_sink_fifo #(
        .DEPTH (DEPTH),
        .W     (ACC_WIDTH + ID_WIDTH)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .i_clr        (~init_n),
        .i_wr         (w_wr),
        .i_rd         (w_rd),
        .i_data       (w_wdata),
        .o_head       (w_head),
        .o_count      (w_count),
        .o_count_next (w_count_next),
        .o_full       (w_full),
        .o_empty      (w_empty)
    );

    // accept_n asserts one slot early so a result already in flight has a skid entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_accept_n <= 1'b1;
            r_exp_id   <= '0;
            r_ovf      <= 1'b0;
            r_id_err   <= 1'b0;
        end else if (!init_n) begin
            r_accept_n <= 1'b0;
            r_exp_id   <= '0;
            r_ovf      <= 1'b0;
            r_id_err   <= 1'b0;
        end else begin
            r_accept_n <= (w_count_next >= ALMOST_FULL);
            if (w_capture) r_exp_id <= r_exp_id + ID_WIDTH'(1);
            if (w_drop)    r_ovf    <= 1'b1;
            if (w_tag_bad) r_id_err <= 1'b1;
        end
    end

    assign accept_n  = r_accept_n;
    assign out_valid = ~w_empty;
    assign out_acc   = w_head.acc;
    assign out_id    = w_head.id;
    assign count     = w_count;
    assign ovf       = r_ovf;
    assign id_err    = r_id_err;

endmodule

// File: tb/tb_mac_result_sink.sv
// Directed vector bench for mac_result_sink (ACC_WIDTH=16, ID_WIDTH=2, DEPTH=4).
module tb_mac_result_sink;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        init_n = 1'b1;
    logic        arrive = 1'b0;
    logic        push_out_n = 1'b1;
    logic [15:0] acc = '0;
    logic [1:0]  arrive_id = '0;
    logic        accept_n;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_acc;
    logic [1:0]  out_id;
    logic [2:0]  count;
    logic        ovf;
    logic        id_err;

    int total = 0;
    int bad   = 0;

    mac_result_sink #(.ACC_WIDTH(16), .ID_WIDTH(2), .DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .init_n     (init_n),
        .arrive     (arrive),
        .push_out_n (push_out_n),
        .acc        (acc),
        .arrive_id  (arrive_id),
        .accept_n   (accept_n),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_acc    (out_acc),
        .out_id     (out_id),
        .count      (count),
        .ovf        (ovf),
        .id_err     (id_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        cap;
        logic        ready;
        logic        init_n;
        logic [15:0] acc;
        logic [1:0]  id;
        logic        e_valid;
        logic [15:0] e_acc;
        logic [1:0]  e_id;
        logic [2:0]  e_count;
        logic        e_accn;
        logic        e_ovf;
        logic        e_iderr;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic cap, logic ready, logic ini, logic [15:0] a, logic [1:0] id,
                                logic ev, logic [15:0] ea, logic [1:0] eid, logic [2:0] ec,
                                logic ean, logic eo, logic ee);
        vec_t v;
        v.cap = cap; v.ready = ready; v.init_n = ini; v.acc = a; v.id = id;
        v.e_valid = ev; v.e_acc = ea; v.e_id = eid; v.e_count = ec;
        v.e_accn = ean; v.e_ovf = eo; v.e_iderr = ee;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic cap, input logic ready, input logic ini,
                         input logic [15:0] a, input logic [1:0] id);
        arrive     = cap;
        push_out_n = ~cap;
        out_ready  = ready;
        init_n     = ini;
        acc        = a;
        arrive_id  = id;
    endtask

    initial begin
        //        cap rdy ini acc      id  | vld acc      id c  an ov ie
        vq.push_back(mk(1, 0, 1, 16'h1234, 0,  1, 16'h1234, 0, 1, 0, 0, 0));
        vq.push_back(mk(0, 1, 1, 16'h0000, 0,  0, 16'h0000, 0, 0, 0, 0, 0));
        vq.push_back(mk(1, 0, 1, 16'h1111, 1,  1, 16'h1111, 1, 1, 0, 0, 0));
        vq.push_back(mk(1, 0, 1, 16'h2222, 2,  1, 16'h1111, 1, 2, 0, 0, 0));
        vq.push_back(mk(1, 0, 1, 16'h3333, 3,  1, 16'h1111, 1, 3, 1, 0, 0));
        vq.push_back(mk(1, 0, 1, 16'h4444, 0,  1, 16'h1111, 1, 4, 1, 0, 0));
        vq.push_back(mk(1, 1, 1, 16'h5555, 1,  1, 16'h2222, 2, 4, 1, 0, 0));
        vq.push_back(mk(1, 0, 1, 16'h6666, 2,  1, 16'h2222, 2, 4, 1, 1, 0));
        vq.push_back(mk(0, 1, 1, 16'h0000, 0,  1, 16'h3333, 3, 3, 1, 1, 0));
        vq.push_back(mk(0, 1, 1, 16'h0000, 0,  1, 16'h4444, 0, 2, 0, 1, 0));
        vq.push_back(mk(0, 1, 1, 16'h0000, 0,  1, 16'h5555, 1, 1, 0, 1, 0));
        vq.push_back(mk(0, 1, 1, 16'h0000, 0,  0, 16'h0000, 0, 0, 0, 1, 0));
        vq.push_back(mk(1, 1, 0, 16'h7777, 3,  0, 16'h0000, 0, 0, 0, 0, 0));
        vq.push_back(mk(1, 0, 1, 16'hA000, 0,  1, 16'hA000, 0, 1, 0, 0, 0));
        vq.push_back(mk(1, 0, 1, 16'hA001, 1,  1, 16'hA000, 0, 2, 0, 0, 0));
        vq.push_back(mk(1, 0, 1, 16'hA003, 3,  1, 16'hA000, 0, 3, 1, 0, 1));
        vq.push_back(mk(0, 1, 1, 16'h0000, 0,  1, 16'hA001, 1, 2, 0, 0, 1));
        vq.push_back(mk(0, 1, 1, 16'h0000, 0,  1, 16'hA003, 3, 1, 0, 0, 1));
        vq.push_back(mk(0, 1, 1, 16'h0000, 0,  0, 16'h0000, 0, 0, 0, 0, 1));
        vq.push_back(mk(1, 0, 1, 16'hB000, 3,  1, 16'hB000, 3, 1, 0, 0, 1));
        vq.push_back(mk(1, 0, 1, 16'hB001, 0,  1, 16'hB000, 3, 2, 0, 0, 1));
        vq.push_back(mk(1, 1, 0, 16'hB002, 1,  0, 16'h0000, 0, 0, 0, 0, 0));
        vq.push_back(mk(0, 0, 1, 16'h0000, 0,  0, 16'h0000, 0, 0, 0, 0, 0));

        // Reset state while rst is held.
        #12;
        chk("rst_count",    32'(count),     32'd0);
        chk("rst_valid",    32'(out_valid), 32'd0);
        chk("rst_accept_n", 32'(accept_n),  32'd1);
        chk("rst_ovf",      32'(ovf),       32'd0);
        chk("rst_id_err",   32'(id_err),    32'd0);
        rst = 1'b0;
        tick();
        chk("rel_accept_n", 32'(accept_n), 32'd0);

        foreach (vq[i]) begin
            drive(vq[i].cap, vq[i].ready, vq[i].init_n, vq[i].acc, vq[i].id);
            tick();
            chk($sformatf("v%0d_valid", i),    32'(out_valid), 32'(vq[i].e_valid));
            chk($sformatf("v%0d_count", i),    32'(count),     32'(vq[i].e_count));
            chk($sformatf("v%0d_accept_n", i), 32'(accept_n),  32'(vq[i].e_accn));
            chk($sformatf("v%0d_ovf", i),      32'(ovf),       32'(vq[i].e_ovf));
            chk($sformatf("v%0d_id_err", i),   32'(id_err),    32'(vq[i].e_iderr));
            if (vq[i].e_valid) begin
                chk($sformatf("v%0d_acc", i), 32'(out_acc), 32'(vq[i].e_acc));
                chk($sformatf("v%0d_id", i),  32'(out_id),  32'(vq[i].e_id));
            end
        end

        // Fill to three entries, then pulse rst asynchronously between edges.
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b0, 1'b1, 16'hD000 + 16'(k), 2'(k));
            tick();
        end
        drive(1'b0, 1'b0, 1'b1, 16'h0000, 2'd0);
        chk("pre_rst_count",    32'(count),    32'd3);
        chk("pre_rst_accept_n", 32'(accept_n), 32'd1);
        #3 rst = 1'b1;
        #1;
        chk("async_count",    32'(count),     32'd0);
        chk("async_valid",    32'(out_valid), 32'd0);
        chk("async_accept_n", 32'(accept_n),  32'd1);
        #1 rst = 1'b0;
        #1;
        chk("held_accept_n", 32'(accept_n), 32'd1);
        tick();
        chk("post_rst_accept_n", 32'(accept_n), 32'd0);
        chk("post_rst_count",    32'(count),    32'd0);

        // Pointers and tag restart cleanly: a tag-0 capture lands at the head with no error.
        drive(1'b1, 1'b0, 1'b1, 16'hC0DE, 2'd0);
        tick();
        drive(1'b0, 1'b0, 1'b1, 16'h0000, 2'd0);
        chk("restart_acc",    32'(out_acc), 32'hC0DE);
        chk("restart_count",  32'(count),   32'd1);
        chk("restart_id_err", 32'(id_err),  32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end

endmodule

// File: doc/mac_result_sink.md
MAC_RESULT_SINK -- requirements
Module: mac_result_sink

Interface
Parameters:
REQ-001 The block SHALL have parameter ACC_WIDTH, default 16, which sets the accumulator result width.
REQ-002 The block SHALL have parameter ID_WIDTH, default 1, which sets the launch/arrive tag width.
REQ-003 The block SHALL have parameter DEPTH, default 4, which sets the result FIFO entries; legal values are powers of 2, at least 2.
Ports:
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 The block SHALL have port init_n, input, 1 bit: synchronous clear, active-low.
REQ-007 The block SHALL have port arrive, input, 1 bit: the producing MAC pipeline has a result at its output.
REQ-008 The block SHALL have port push_out_n, input, 1 bit: the result is pushed this cycle, active-low.
REQ-009 The block SHALL have port acc, input, ACC_WIDTH bits: the result data.
REQ-010 The block SHALL have port arrive_id, input, ID_WIDTH bits: the result tag.
REQ-011 The block SHALL have port accept_n, output, 1 bit: backpressure to the producer; low means results are accepted.
REQ-012 The block SHALL have port out_valid, output, 1 bit: the FIFO head is valid.
REQ-013 The block SHALL have port out_ready, input, 1 bit: the downstream consumer takes the head.
REQ-014 The block SHALL have port out_acc, output, ACC_WIDTH bits: head data.
REQ-015 The block SHALL have port out_id, output, ID_WIDTH bits: head tag.
REQ-016 The block SHALL have port count, output, clog2(DEPTH)+1 bits: FIFO occupancy.
REQ-017 The block SHALL have port ovf, output, 1 bit: sticky flag, result dropped while full.
REQ-018 The block SHALL have port id_err, output, 1 bit: sticky flag, out-of-order tag received.

Function
REQ-019 The capture event SHALL be arrive=1 AND push_out_n=0, sampled on the rising clk edge.
REQ-020 On a capture while count<DEPTH, the block SHALL write {acc, arrive_id} at the tail; the entry SHALL be visible at out_* on the next cycle (1-cycle latency).
REQ-021 A pop SHALL occur when out_valid=1 AND out_ready=1; the head then advances.
REQ-022 A capture and a pop in the same cycle SHALL leave count unchanged; when count=DEPTH, the pop frees a slot first, so the capture is stored and ovf is not set.
REQ-023 A capture while count=DEPTH without a simultaneous pop SHALL drop the data and set ovf, which holds until reset or init_n=0.
REQ-024 A pop attempt while empty SHALL have no effect.
REQ-025 accept_n SHALL be registered and equal 1 in the cycle after count_next >= DEPTH-1; otherwise 0.
REQ-026 This gives one skid entry to absorb a result already in flight.
REQ-027 out_valid SHALL equal (count != 0).
REQ-028 out_acc and out_id SHALL hold the head entry; they are don't-care while empty.
REQ-029 An expected-tag register SHALL start at 0 and increment modulo 2^ID_WIDTH on every capture, including dropped captures.
REQ-030 On a capture with arrive_id != expected, the block SHALL set id_err, which is sticky; the data is still stored.
REQ-031 Read and write pointers SHALL wrap modulo DEPTH.
REQ-032 count SHALL range 0..DEPTH.
REQ-033 init_n=0 SHALL, synchronously, empty the FIFO, zero the expected tag, and clear ovf and id_err, accept_n and count; init_n has priority over capture and pop in the same cycle.

Reset
REQ-034 While rst=1, asynchronously: count=0, out_valid=0, accept_n=1, ovf=0, id_err=0, pointers=0, expected tag=0.
REQ-035 accept_n SHALL fall to 0 on the first clk edge after rst deasserts.
REQ-036 FIFO storage SHALL NOT be reset.
REQ-037 A reset asserted mid-transfer SHALL discard all stored entries; no partial state survives.

Structure
REQ-038 Package mac_sink_pkg SHALL hold the default ACC_WIDTH, ID_WIDTH and DEPTH, the pointer-width function, and the entry record type {acc, id}.
REQ-039 FIFO storage and pointers SHALL be in one sub-module, mac_sink_fifo.
REQ-040 The top level SHALL hold the capture qualification, the accept_n register, the tag check and the sticky flags.

Verification
REQ-041 Reset then a single capture (acc=0x1234, id=0) -> next cycle out_valid=1, out_acc=0x1234, count=1; with out_ready=1, count=0 one cycle later.
REQ-042 DEPTH=4, out_ready=0, 3 captures -> accept_n=1 the cycle after the 3rd; a 4th capture is stored (count=4); a 5th sets ovf=1 with count staying 4.
REQ-043 Full FIFO, then capture and pop in the same cycle -> count stays 4, ovf=0, new data at the tail, order preserved.
REQ-044 ID_WIDTH=2, tags 0,1,3 -> id_err=1 after the third capture; all three entries are stored.
REQ-045 rst pulsed asynchronously mid-cycle with count=3 -> out_valid=0, count=0, accept_n=1 immediately; accept_n=0 on the next edge after release.
REQ-046 init_n=0 together with a capture and a pop -> count=0, ovf=0, id_err=0 the next cycle; the captured data is discarded.
